// File: rtl/slew_limiter_scheduler.sv
// rtl/slew_limiter_scheduler.sv - time-multiplexed per-channel slew-rate limiter
// One subtract/clamp unit walks all channels per sample frame; outputs commit together.
module slew_limiter_scheduler #(
    parameter int  NUM_CHANNELS          = 4,
    parameter int  SIGNAL_FRACTION_WIDTH = 14,
    parameter real VCC                   = 12.0,
    parameter real SAMPLE_RATE           = 48000.0,
    parameter real MAX_CHANGE_RATE       = 1000.0
) (
    input  logic                      clk,
    input  logic                      I_RST,
    input  logic                      audio_clk_en,
    input  logic [16*NUM_CHANNELS-1:0] in,
    input  logic [NUM_CHANNELS-1:0]   bypass,
    input  logic                      overrun_clr,
    output logic [16*NUM_CHANNELS-1:0] out,
    output logic                      sample_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam real STEP_REAL = real'(1 << SIGNAL_FRACTION_WIDTH) * MAX_CHANGE_RATE
                                / VCC / SAMPLE_RATE;
    localparam int  STEP_RAW  = $rtoi(STEP_REAL);
    localparam int  MAX_STEP  = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam logic signed [16:0] STEP17 = 17'(MAX_STEP);
    localparam logic signed [15:0] STEP16 = 16'(MAX_STEP);
    localparam int  IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [15:0]        snap_q [NUM_CHANNELS];
    logic signed [15:0]        snap_d [NUM_CHANNELS];
    logic signed [15:0]        work_q [NUM_CHANNELS];
    logic signed [15:0]        work_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]   byp_q, byp_d;
    logic [16*NUM_CHANNELS-1:0] out_q, out_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;

    logic signed [15:0]        cur_snap, cur_work, next_val;
    logic signed [16:0]        delta;

    // Shared limiter: the result always lies between work and snapshot, so no overflow.
    always_comb begin
        cur_snap = snap_q[idx_q];
        cur_work = work_q[idx_q];
        delta    = {cur_snap[15], cur_snap} - {cur_work[15], cur_work};
        if (byp_q[idx_q]) begin
            next_val = cur_snap;
        end else if (delta > STEP17) begin
            next_val = cur_work + STEP16;
        end else if (delta < -STEP17) begin
            next_val = cur_work - STEP16;
        end else begin
            next_val = cur_snap;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        work_d  = work_q;
        byp_d   = byp_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;

        // A strobe while sequencing is dropped but remembered; set beats clear.
        if (audio_clk_en && (state_q == RUN)) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    state_d = RUN;
                    idx_d   = '0;
                    byp_d   = bypass;
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        snap_d[k] = in[16*k +: 16];
                    end
                end
            end
            RUN: begin
                work_d[idx_q] = next_val;
                if (idx_q == LAST) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        out_d[16*k +: 16] = work_d[k];
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            byp_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                snap_q[k] <= '0;
                work_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byp_q   <= byp_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                snap_q[k] <= snap_d[k];
                work_q[k] <= work_d[k];
            end
        end
    end

    assign out          = out_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == RUN);
    assign overrun      = ovr_q;

endmodule
